rv_mem_arb: RTL

Arbiter and sequencer that shares one single-port synchronous memory between the rv_cpu instruction-fetch port and its data port. It accepts at most one request per cycle and drives the memory. It routes the 1-cycle-latency read data back to the owning requester. It bounds fetch starvation with a consecutive-data-grant counter. It sits between rv_cpu and a unified wrap_mem-style memory, replacing separate IMEM/DMEM instances in the top-level bench.

---
 rtl/rv_mem_arb.sv | 119 +++++++++++
 1 files changed

// File: rtl/rv_mem_arb.sv
// Shares one single-port synchronous memory between the fetch and data ports of rv_cpu.
// Grant is combinational in the request cycle. Each response comes exactly 1 cycle after accept. Responses cannot be backpressured.
module rv_mem_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    input  logic                if_flush,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                d_req_valid,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic                d_req_wr_en,
    input  logic [DATA_W/8-1:0] d_req_byte_en,
    input  logic [DATA_W-1:0]   d_req_wr_data,
    output logic                d_req_ready,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                mem_rd_en,
    output logic                mem_wr_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_byte_en,
    output logic [DATA_W-1:0]   mem_wr_data,
    input  logic [DATA_W-1:0]   mem_rd_data
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DRD,
        OWN_DWR
    } owner_t;

    owner_t     owner_q, owner_d;
    logic [3:0] starve_q, starve_d;
    logic       grant_if, grant_d;

    // Data wins contention until it has starved a waiting fetch STARVE_MAX times in a row.
    always_comb begin
        grant_if = rst & if_req_valid & (~d_req_valid | (starve_q >= STARVE_LIM));
        grant_d  = rst & d_req_valid & ~grant_if;
    end

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;

    always_comb begin
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_byte_en = '0;
        mem_wr_data = '0;
        if (grant_if) begin
            mem_rd_en   = 1'b1;
            mem_addr    = if_req_addr;
            mem_byte_en = '1;
        end else if (grant_d) begin
            mem_addr = d_req_addr;
            if (d_req_wr_en) begin
                mem_wr_en   = 1'b1;
                mem_byte_en = d_req_byte_en;
                mem_wr_data = d_req_wr_data;
            end else begin
                mem_rd_en = 1'b1;
            end
        end
    end

    always_comb begin
        owner_d  = OWN_NONE;
        starve_d = 4'd0;
        if (grant_if) begin
            owner_d = OWN_IF;
        end else if (grant_d) begin
            owner_d = d_req_wr_en ? OWN_DWR : OWN_DRD;
        end
        if (grant_d && if_req_valid) begin
            starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q  <= OWN_NONE;
            starve_q <= 4'd0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // Owner is forced to NONE while reset is held, so every response output is 0 during reset.
    always_comb begin
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        d_rsp_valid  = 1'b0;
        d_rsp_data   = '0;
        case (owner_q)
            OWN_IF: begin
                if_rsp_valid = ~if_flush;
                if_rsp_data  = mem_rd_data;
            end
            OWN_DRD: begin
                d_rsp_valid = 1'b1;
                d_rsp_data  = mem_rd_data;
            end
            OWN_DWR: begin
                d_rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
